// File: rtl/stack_unit.sv
// stack_unit: register-based LIFO for call/return and stack instructions.
// Pops return the word one cycle after the request on pop_data/pop_valid.
// A simultaneous push+pop on a non-empty stack replaces the top entry.
module stack_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  clear_err,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] top,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  // Request semantics: push and pop are single-cycle requests with no
  // back-pressure. Each one sampled at a rising edge is either performed on
  // that edge or dropped, and the matching sticky error flag is set. A
  // performed pop produces exactly one pop_valid pulse in the following cycle.

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] top_idx;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  do_write;
  logic                  replace;

  // Status and top-of-stack peek, combinational from count and storage.
  always_comb begin
    full    = (count == DEPTH_C);
    empty   = (count == '0);
    top_idx = ADDR_WIDTH'(count - 1'b1);
    top     = empty ? '0 : mem[top_idx];
  end

  // Decide whether storage is written this edge and at which slot.
  always_comb begin
    replace  = push && pop && !empty;
    do_write = push && (replace || !full);
    wr_idx   = replace ? top_idx : count[ADDR_WIDTH-1:0];
  end

  // Storage write; contents are not reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_idx] <= push_data;
    end
  end

  // Stack pointer, pop result and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= 1'b0;
      // Clearing first lets an error on this same edge win over clear_err.
      if (clear_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      case ({push, pop})
        2'b10: begin
          if (full) overflow <= 1'b1;
          else      count    <= count + 1'b1;
        end
        2'b01: begin
          if (empty) begin
            underflow <= 1'b1;
          end else begin
            pop_data  <= mem[top_idx];
            pop_valid <= 1'b1;
            count     <= count - 1'b1;
          end
        end
        2'b11: begin
          if (empty) begin
            // The push lands in slot 0; the pop is dropped (no bypass).
            count     <= count + 1'b1;
            underflow <= 1'b1;
          end else begin
            pop_data  <= mem[top_idx];
            pop_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: reset, LIFO order, overflow, underflow,
// replace-top on full and empty stacks, and back-to-back pops.
module tb_stack_unit;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          clear_err = 1'b0;
  logic [DW-1:0] pop_data;
  logic          pop_valid;
  logic [DW-1:0] top;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  stack_unit #(.DATA_WIDTH(DW), .DEPTH(16), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .clear_err(clear_err), .pop_data(pop_data), .pop_valid(pop_valid),
    .top(top), .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  // Clock
  always #5 clk = ~clk;

  // One edge with the given request; outputs settle #1 after the edge.
  task automatic cycle(input logic p, input logic q, input logic [DW-1:0] d,
                       input logic c);
    push = p; pop = q; push_data = d; clear_err = c;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; clear_err = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || pop_valid !== 1'b0 ||
        overflow !== 1'b0 || underflow !== 1'b0 || pop_data !== '0) begin
      errors++;
      $display("FAIL reset_state got count=%0d empty=%b full=%b pv=%b ovf=%b unf=%b pd=%h exp 0 1 0 0 0 0 0",
               count, empty, full, pop_valid, overflow, underflow, pop_data);
    end
    @(negedge clk); rst = 1'b0;
    // Build count=4, then pop so a pop_valid pulse is live with count=3.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'hA0 + i, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (count !== 5'd3 || pop_valid !== 1'b1 || pop_data !== 32'hA3) begin
      errors++;
      $display("FAIL pre_reset got count=%0d pv=%b pd=%h exp 3 1 a3", count, pop_valid, pop_data);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || pop_valid !== 1'b0 ||
        overflow !== 1'b0 || underflow !== 1'b0 || top !== '0) begin
      errors++;
      $display("FAIL async_reset got count=%0d empty=%b pv=%b ovf=%b unf=%b top=%h exp 0 1 0 0 0 0",
               count, empty, pop_valid, overflow, underflow, top);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_lifo;
    logic [DW-1:0] e;
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b1, 1'b0, 32'h11 * i, 1'b0);
      exp_q.push_back(32'h11 * i);
      checks++;
      if (top !== 32'h11 * i) begin
        errors++;
        $display("FAIL lifo_top got %h exp %h", top, 32'h11 * i);
      end
    end
    // Three consecutive pop edges.
    pop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      e = exp_q.pop_back();
      checks++;
      if (pop_valid !== 1'b1 || pop_data !== e) begin
        errors++;
        $display("FAIL lifo_pop%0d got pv=%b pd=%h exp 1 %h", i, pop_valid, pop_data, e);
      end
    end
    pop = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pop_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || top !== '0) begin
      errors++;
      $display("FAIL lifo_end got pv=%b count=%0d empty=%b top=%h exp 0 0 1 0",
               pop_valid, count, empty, top);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 32'h100 + i, 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0 || top !== 32'h10F) begin
      errors++;
      $display("FAIL full_16 got full=%b count=%0d ovf=%b top=%h exp 1 16 0 10f",
               full, count, overflow, top);
    end
    cycle(1'b1, 1'b0, 32'h110, 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1 || top !== 32'h10F) begin
      errors++;
      $display("FAIL overflow_17 got full=%b count=%0d ovf=%b top=%h exp 1 16 1 10f",
               full, count, overflow, top);
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (overflow !== 1'b0 || count !== 5'd16) begin
      errors++;
      $display("FAIL overflow_clear got ovf=%b count=%0d exp 0 16", overflow, count);
    end
  endtask

  task automatic test_replace_full;
    cycle(1'b1, 1'b1, 32'hABCD, 1'b0);
    checks++;
    if (pop_data !== 32'h10F || pop_valid !== 1'b1 || count !== 5'd16 ||
        top !== 32'hABCD || overflow !== 1'b0) begin
      errors++;
      $display("FAIL replace_full got pd=%h pv=%b count=%0d top=%h ovf=%b exp 10f 1 16 abcd 0",
               pop_data, pop_valid, count, top, overflow);
    end
  endtask

  task automatic test_back_to_back;
    exp_q = {};
    for (int i = 0; i < 15; i++) exp_q.push_back(32'h100 + i);
    exp_q.push_back(32'hABCD);
    pop = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] e;
      @(posedge clk); #1;
      e = exp_q.pop_back();
      checks++;
      if (pop_valid !== 1'b1 || pop_data !== e || count !== 5'(15 - i)) begin
        errors++;
        $display("FAIL b2b_pop%0d got pv=%b pd=%h count=%0d exp 1 %h %0d",
                 i, pop_valid, pop_data, count, e, 15 - i);
      end
    end
    pop = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (pop_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end got pv=%b empty=%b exp 0 1", pop_valid, empty);
    end
  endtask

  task automatic test_underflow;
    cycle(1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (pop_valid !== 1'b0 || underflow !== 1'b1 || count !== 5'd0 || pop_data !== 32'h100) begin
      errors++;
      $display("FAIL underflow got pv=%b unf=%b count=%0d pd=%h exp 0 1 0 100",
               pop_valid, underflow, count, pop_data);
    end
    // Error on the same edge as clear_err: the set wins.
    cycle(1'b0, 1'b1, '0, 1'b1);
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL set_wins got unf=%b exp 1", underflow);
    end
    cycle(1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear got unf=%b exp 0", underflow);
    end
  endtask

  task automatic test_replace_empty;
    cycle(1'b1, 1'b1, 32'h5, 1'b0);
    checks++;
    if (count !== 5'd1 || top !== 32'h5 || pop_valid !== 1'b0 || underflow !== 1'b1 ||
        empty !== 1'b0) begin
      errors++;
      $display("FAIL replace_empty got count=%0d top=%h pv=%b unf=%b empty=%b exp 1 5 0 1 0",
               count, top, pop_valid, underflow, empty);
    end
    cycle(1'b0, 1'b1, '0, 1'b0);
    checks++;
    if (pop_data !== 32'h5 || pop_valid !== 1'b1 || count !== 5'd0) begin
      errors++;
      $display("FAIL replace_empty_pop got pd=%h pv=%b count=%0d exp 5 1 0",
               pop_data, pop_valid, count);
    end
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_lifo();
    test_overflow();
    test_replace_full();
    test_back_to_back();
    test_underflow();
    test_replace_empty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware LIFO that services the push/pop request pair issued by the decode stage.
- Holds return addresses and data words for call/return and stack instructions.
- Sits beside the execute/memory stages and returns popped words to the datapath one cycle after the request.
- Single clock domain; all storage is internal registers.

Parameters:
- DATA_WIDTH, 32, width of each stack entry.
- DEPTH, 16, number of entries (power of two).
- ADDR_WIDTH, 4, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- push  input  1  push request, sampled on rising clk.
- pop  input  1  pop request, sampled on rising clk.
- push_data  input  DATA_WIDTH  word to push.
- clear_err  input  1  synchronous clear of sticky error flags.
- pop_data  output  DATA_WIDTH  registered popped word.
- pop_valid  output  1  one-cycle pulse; pop_data is valid.
- top  output  DATA_WIDTH  combinational peek of the current top of stack; 0 when empty.
- count  output  ADDR_WIDTH+1  number of valid entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a push was dropped.
- underflow  output  1  sticky: a pop was dropped.

Behaviour:
- Reset: clk and rst only; rst asserted asynchronously forces the following:
  - count, pop_data, pop_valid, overflow and underflow all 0.
  - empty=1, full=0.
  - Storage contents need not be cleared.
- Reset mid-operation: any in-flight request is discarded and no pop_valid is issued.
- Storage: array mem[0..DEPTH-1]. The stack pointer equals count. The top entry is mem[count-1].
- All state updates happen on the rising clk edge. full, empty and top are combinational from count and mem.
- Cases per cycle (push, pop):
  - 0,0: hold. pop_valid=0 next cycle.
  - 1,0, not full: mem[count] <= push_data; count+1.
  - 1,0, full: push dropped, count held, overflow <= 1.
  - 0,1, not empty: pop_data <= mem[count-1]; pop_valid <= 1; count-1.
  - 0,1, empty: pop dropped, pop_valid <= 0, underflow <= 1, pop_data held.
  - 1,1, not empty (including full): replace top. The following all happen on the same edge:
    - pop_data <= old mem[count-1].
    - mem[count-1] <= push_data.
    - pop_valid <= 1.
    - count unchanged.
    - No overflow, even when full.
  - 1,1, empty: the push proceeds (mem[0] <= push_data, count=1). The pop is dropped with underflow <= 1 and pop_valid=0. There is no bypass.
- Latency: pop_data and pop_valid are valid exactly one cycle after the pop edge. pop_valid is never high two cycles from a single request.
- Back-to-back pops on consecutive cycles return successive entries every cycle.
- Error flags:
  - Once set, overflow and underflow stay set until clear_err=1 at an edge, which clears both.
  - If an error occurs on the same edge as clear_err, the set wins.
- Width rules: count never exceeds DEPTH and never wraps below 0. Pointer arithmetic uses ADDR_WIDTH+1 bits.
- top reflects the post-edge state. After a push, top equals the pushed word in the next cycle.

Test Plan:
- Reset: assert rst mid-cycle with count=3 -> count=0, empty=1, pop_valid=0, overflow=underflow=0 immediately, with no clock edge required.
- LIFO order: push 0x11, 0x22, 0x33, then pop three times on consecutive cycles -> pop_data 0x33, 0x22, 0x11 with pop_valid high for 3 cycles; count ends at 0 and empty=1.
- Full/overflow: push 17 words 0x100..0x110 with DEPTH=16 -> full=1 after the 16th push, count=16, overflow=1, top=0x10F. Then clear_err -> overflow=0.
- Underflow: pop while empty -> pop_valid stays 0, underflow=1, count=0, pop_data unchanged.
- Simultaneous on full stack: with the stack full and top=0x10F, push=pop=1 with push_data=0xABCD -> pop_data=0x10F, pop_valid=1, count=16, top=0xABCD, overflow=0.
- Simultaneous on empty: push=pop=1 with push_data=0x5 -> count=1, top=0x5, pop_valid=0, underflow=1.
